mux_bank16: RTL and testbench

- Width-parameterised selector bank: a 2-way, a 4-way and an 8-way multiplexer share one data input set and one select bus.
- Each mux has a combinational output and a registered copy.
- Used as the word-select primitive in datapath blocks (register-file read, ALU operand select). The combinational outputs feed same-cycle logic; the registered outputs feed pipelined consumers.

---
 rtl/mux_bank16_pkg.sv | 8 +
 rtl/mux_bank16_mux2_w.sv | 16 +
 rtl/mux_bank16.sv | 88 ++++++++
 tb/tb_mux_bank16.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_bank16_pkg.sv
// Shared constants for the mux_bank16 selector bank.
// Data width default and select-bus width live here so every file agrees.
package mux_bank16_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned SEL_WIDTH     = 3;

endpackage : mux_bank16_pkg

// File: rtl/mux_bank16_mux2_w.sv
// WIDTH-bit 2:1 selector, the leaf cell of every mux tree in mux_bank16.
// Plain conditional so X/Z on the select propagates with standard semantics.
module mux2_w
  import mux_bank16_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_sel ? i_in1 : i_in0;

endmodule : mux2_w

// File: rtl/mux_bank16.sv
// 2-, 4- and 8-way selectors sharing one data set and select bus, each with a
// combinational output and a one-cycle registered copy cleared by async reset.
module mux_bank16
  import mux_bank16_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  input  logic [WIDTH-1:0]     e,
  input  logic [WIDTH-1:0]     f,
  input  logic [WIDTH-1:0]     g,
  input  logic [WIDTH-1:0]     h,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [WIDTH-1:0]     mux,
  output logic [WIDTH-1:0]     mux4,
  output logic [WIDTH-1:0]     mux8,
  output logic [WIDTH-1:0]     mux_q,
  output logic [WIDTH-1:0]     mux4_q,
  output logic [WIDTH-1:0]     mux8_q
);

  logic [WIDTH-1:0] w_ab;
  logic [WIDTH-1:0] w_cd;
  logic [WIDTH-1:0] w_ef;
  logic [WIDTH-1:0] w_gh;
  logic [WIDTH-1:0] w_abcd;
  logic [WIDTH-1:0] w_efgh;
  logic [WIDTH-1:0] w_all;

  logic [WIDTH-1:0] r_mux;
  logic [WIDTH-1:0] r_mux4;
  logic [WIDTH-1:0] r_mux8;

  // Level 1: pairwise on sel[0]; the a/b pair doubles as the 2-way result.
  mux2_w #(.WIDTH(WIDTH)) u_ab (.i_in0(a), .i_in1(b), .i_sel(sel[0]), .o_out(w_ab));
  mux2_w #(.WIDTH(WIDTH)) u_cd (.i_in0(c), .i_in1(d), .i_sel(sel[0]), .o_out(w_cd));
  mux2_w #(.WIDTH(WIDTH)) u_ef (.i_in0(e), .i_in1(f), .i_sel(sel[0]), .o_out(w_ef));
  mux2_w #(.WIDTH(WIDTH)) u_gh (.i_in0(g), .i_in1(h), .i_sel(sel[0]), .o_out(w_gh));

  // Level 2: two 4-way trees on sel[1].
  mux2_w #(.WIDTH(WIDTH)) u_abcd (
    .i_in0 (w_ab),
    .i_in1 (w_cd),
    .i_sel (sel[1]),
    .o_out (w_abcd)
  );

  mux2_w #(.WIDTH(WIDTH)) u_efgh (
    .i_in0 (w_ef),
    .i_in1 (w_gh),
    .i_sel (sel[1]),
    .o_out (w_efgh)
  );

  // Level 3: pick between the two 4-way trees on sel[2].
  mux2_w #(.WIDTH(WIDTH)) u_all (
    .i_in0 (w_abcd),
    .i_in1 (w_efgh),
    .i_sel (sel[2]),
    .o_out (w_all)
  );

  assign mux  = w_ab;
  assign mux4 = w_abcd;
  assign mux8 = w_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux  <= '0;
      r_mux4 <= '0;
      r_mux8 <= '0;
    end else begin
      r_mux  <= w_ab;
      r_mux4 <= w_abcd;
      r_mux8 <= w_all;
    end
  end

  assign mux_q  = r_mux;
  assign mux4_q = r_mux4;
  assign mux8_q = r_mux8;

endmodule : mux_bank16

// File: tb/tb_mux_bank16.sv
// Scoreboard bench for mux_bank16: stimulus pushes expected per-cycle outputs,
// a monitor on the falling edge pops and compares them.
module tb_mux_bank16;

  typedef struct {
    string       tag;
    logic [15:0] m;
    logic [15:0] m4;
    logic [15:0] m8;
    logic [15:0] mq;
    logic [15:0] m4q;
    logic [15:0] m8q;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] dat [8];
  logic [2:0]  sel;
  logic [15:0] mux, mux4, mux8, mux_q, mux4_q, mux8_q;

  exp_t        sb_q [$];
  int          n_checks;
  int          n_fail;
  bit          stim_done;

  // Bench model of the registered stage.
  logic [15:0] mdl_mq, mdl_m4q, mdl_m8q;

  mux_bank16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (dat[0]),
    .b      (dat[1]),
    .c      (dat[2]),
    .d      (dat[3]),
    .e      (dat[4]),
    .f      (dat[5]),
    .g      (dat[6]),
    .h      (dat[7]),
    .sel    (sel),
    .mux    (mux),
    .mux4   (mux4),
    .mux8   (mux8),
    .mux_q  (mux_q),
    .mux4_q (mux4_q),
    .mux8_q (mux8_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_pattern(input int pat);
    for (int i = 0; i < 8; i++) begin
      if (pat == 0) dat[i] = 16'(i);
      else          dat[i] = 16'h1111 * 16'(i);
    end
    if (pat == 1) begin
      dat[0] = 16'hAAAA;
      dat[7] = 16'h5555;
    end
  endtask

  // One cycle: model the edge, drive new inputs, push the expected outputs.
  task automatic step(input logic rst, input logic [2:0] s, input int pat, input string tag);
    exp_t x;
    @(posedge clk);
    if (rst_n) begin
      mdl_mq  = dat[{2'b00, sel[0]}];
      mdl_m4q = dat[{1'b0, sel[1:0]}];
      mdl_m8q = dat[sel];
    end else begin
      mdl_mq  = '0;
      mdl_m4q = '0;
      mdl_m8q = '0;
    end
    #1;
    load_pattern(pat);
    sel   = s;
    rst_n = rst;
    if (!rst) begin
      mdl_mq  = '0;
      mdl_m4q = '0;
      mdl_m8q = '0;
    end
    x.tag = tag;
    x.m   = dat[{2'b00, s[0]}];
    x.m4  = dat[{1'b0, s[1:0]}];
    x.m8  = dat[s];
    x.mq  = mdl_mq;
    x.m4q = mdl_m4q;
    x.m8q = mdl_m8q;
    sb_q.push_back(x);
  endtask

  task automatic chk(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, expv);
    end
  endtask

  // Monitor: every output is valid every cycle, sample mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk(x.tag, "mux",    mux,    x.m);
        chk(x.tag, "mux4",   mux4,   x.m4);
        chk(x.tag, "mux8",   mux8,   x.m8);
        chk(x.tag, "mux_q",  mux_q,  x.mq);
        chk(x.tag, "mux4_q", mux4_q, x.m4q);
        chk(x.tag, "mux8_q", mux8_q, x.m8q);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    stim_done = 1'b0;
    rst_n     = 1'b0;
    sel       = 3'd0;
    load_pattern(0);

    // Reset held two cycles; combinational outputs still live (all zero at sel 0).
    step(1'b0, 3'd0, 0, "reset0");
    step(1'b0, 3'd0, 0, "reset1");
    // Release with sel 5: first load on the next edge gives 1/1/5.
    step(1'b1, 3'd5, 0, "release");
    step(1'b1, 3'd5, 0, "first_load");
    // Sweep sel 0..7 then wrap to 0.
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 0, $sformatf("sweep%0d", i));
    step(1'b1, 3'd0, 0, "wrap");
    step(1'b1, 3'd0, 0, "wrap_q");
    // Async reset while mux8_q holds 7.
    step(1'b1, 3'd7, 0, "pre7");
    step(1'b1, 3'd7, 0, "hold7");
    step(1'b0, 3'd7, 0, "async_rst");
    step(1'b1, 3'd7, 0, "post_rst");
    step(1'b1, 3'd7, 0, "reload7");
    // Mid-stream reset discards the value in flight.
    step(1'b1, 3'd3, 0, "inflight");
    step(1'b0, 3'd6, 0, "discard");
    step(1'b1, 3'd6, 0, "resume");
    // Distinct pattern, alternating sel 0/7.
    for (int i = 0; i < 8; i++) step(1'b1, (i % 2 == 0) ? 3'd0 : 3'd7, 1, $sformatf("alt%0d", i));
    step(1'b1, 3'd2, 1, "alt_tail");

    repeat (3) @(posedge clk);
    stim_done = 1'b1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_bank16
